fp_add_arbiter: RTL

Round-robin arbiter and sequencer that shares one floating-point adder among up to N_REQ requesters. It accepts operand pairs over per-requester valid/ready handshakes and drives the adder through a start/done handshake. It returns each result and its 4-bit status to the granted requester, holding it until that requester accepts. It sits between the client blocks and the single adder instance, and it is the only block allowed to start the adder.

---
 rtl/fp_add_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one floating-point adder among N_REQ clients.
// Sequences the adder through start/done and holds each result until taken.
module fp_add_arbiter #(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                  clock_100kHz,
   input  logic                  reset,
   input  logic [N_REQ-1:0]      req_valid,
   input  logic [32*N_REQ-1:0]   req_op_a,
   input  logic [32*N_REQ-1:0]   req_op_b,
   output logic [N_REQ-1:0]      req_ready,
   output logic [N_REQ-1:0]      rsp_valid,
   input  logic [N_REQ-1:0]      rsp_ready,
   output logic [31:0]           rsp_data,
   output logic [3:0]            rsp_status,
   output logic                  fpu_start,
   output logic [31:0]           fpu_op_a,
   output logic [31:0]           fpu_op_b,
   input  logic                  fpu_done,
   input  logic [31:0]           fpu_result,
   input  logic [3:0]            fpu_status,
   output logic                  busy
);

   localparam int GW = $clog2(N_REQ);
   localparam int CW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT,
      RESPOND
   } state_t;

   state_t          state_q, state_d;
   logic [GW-1:0]   grant_q, grant_d;
   logic [GW-1:0]   last_grant_q, last_grant_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [31:0]     op_a_q, op_a_d;
   logic [31:0]     op_b_q, op_b_d;
   logic [31:0]     rsp_data_q, rsp_data_d;
   logic [3:0]      rsp_status_q, rsp_status_d;

   logic [GW-1:0]   cand;
   logic [GW-1:0]   idx;
   logic            cand_ok;
   int              sel;

   // Scan farthest-to-nearest so the nearest valid requester after
   // last_grant ends up as the candidate.
   always_comb begin
      cand    = '0;
      cand_ok = 1'b0;
      sel     = 0;
      idx     = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         sel = int'(last_grant_q) + k;
         if (sel >= N_REQ) sel = sel - N_REQ;
         idx = GW'(sel);
         if (req_valid[idx]) begin
            cand    = idx;
            cand_ok = 1'b1;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      rsp_data_d   = rsp_data_q;
      rsp_status_d = rsp_status_q;
      req_ready    = '0;
      rsp_valid    = '0;
      fpu_start    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (reset && cand_ok) begin
               req_ready[cand] = 1'b1;
               op_a_d  = req_op_a[32*int'(cand) +: 32];
               op_b_d  = req_op_b[32*int'(cand) +: 32];
               grant_d = cand;
               state_d = START;
            end
         end
         START: begin
            fpu_start = 1'b1;
            cnt_d     = '0;
            state_d   = WAIT;
         end
         WAIT: begin
            if (fpu_done) begin
               rsp_data_d   = fpu_result;
               rsp_status_d = fpu_status;
               state_d      = RESPOND;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               rsp_data_d   = '0;
               rsp_status_d = 4'hF;
               state_d      = RESPOND;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESPOND: begin
            rsp_valid[grant_q] = 1'b1;
            if (rsp_ready[grant_q]) begin
               last_grant_d = grant_q;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock_100kHz or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         last_grant_q <= GW'(N_REQ - 1);
         cnt_q        <= '0;
         op_a_q       <= '0;
         op_b_q       <= '0;
         rsp_data_q   <= '0;
         rsp_status_q <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         rsp_data_q   <= rsp_data_d;
         rsp_status_q <= rsp_status_d;
      end
   end

   assign fpu_op_a   = op_a_q;
   assign fpu_op_b   = op_b_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_status = rsp_status_q;
   assign busy       = (state_q != IDLE);

endmodule
